// File: rtl/regfile_fwd_scrub.sv
// Register file with EX/MEM/WB bypass, load-use stall detection and a
// zeroing sweep that runs after reset and on request.
module regfile_fwd_scrub #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  ex_we,
    input  logic [ADDR_W-1:0]     ex_waddr,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_is_load,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_waddr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  stall_req
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [NRD-1:0]     load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The last sweep write and the move to RUN share one edge; cnt wraps to 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                cnt_next = cnt + 1'b1;
                if (cnt == '1)
                    state_next = RUN;
            end
            RUN: begin
                if (clear_req) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Array has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[cnt] <= '0;
        else if (we && (waddr != '0))
            regs[waddr] <= wdata;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_port
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_data;
        logic              port_lu;

        assign port_addr = raddr[g*ADDR_W +: ADDR_W];

        // Youngest producer wins; a load in EX has no data yet, so stall instead.
        always_comb begin
            port_data = '0;
            port_lu   = 1'b0;
            if ((state == RUN) && re[g] && (port_addr != '0)) begin
                if (ex_we && (ex_waddr == port_addr)) begin
                    if (ex_is_load)
                        port_lu = 1'b1;
                    else
                        port_data = ex_wdata;
                end else if (mem_we && (mem_waddr == port_addr)) begin
                    port_data = mem_wdata;
                end else if (we && (waddr == port_addr)) begin
                    port_data = wdata;
                end else begin
                    port_data = regs[port_addr];
                end
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = port_data;
        assign load_use[g]               = port_lu;
    end

    assign ready     = (state == RUN);
    assign stall_req = (state == INIT) || (|load_use);

endmodule
